// File: rtl/cpu_bus_lsu.sv
// Load/store unit bridging a single-request core port to a classic bus.
// Handles lane steering, misalignment traps, bus errors and ack timeout.
module cpu_bus_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [DATA_W/8-1:0] sel_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    input  logic              err_i
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] adr_r;
    logic [DATA_W-1:0] dat_r;
    logic [NB-1:0]     sel_r;
    logic [OFF_W-1:0]  off_r;
    logic [1:0]        size_r;
    logic              sgn_r;
    logic              we_r;
    logic              err_r;
    logic [DATA_W-1:0] rdata_r;

    logic [OFF_W-1:0]  off;
    logic              mis;
    logic [7:0]        mask8;
    logic [NB-1:0]     sel_n;
    logic [DATA_W-1:0] dat_n;
    logic [ADDR_W-1:0] adr_n;
    logic              tmo;

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] lmask;
    logic [DATA_W-1:0] ld;
    logic [6:0]        lw;
    logic              sbit;

    assign off = req_addr[OFF_W-1:0];

    always_comb begin
        mis   = 1'b0;
        mask8 = 8'h01;
        unique case (req_size)
            2'b00: begin
                mis   = 1'b0;
                mask8 = 8'h01;
            end
            2'b01: begin
                mis   = req_addr[0];
                mask8 = 8'h03;
            end
            2'b10: begin
                mis   = |req_addr[1:0];
                mask8 = 8'h0F;
            end
            default: begin
                mis   = (DATA_W == 32) || (|req_addr[2:0]);
                mask8 = 8'hFF;
            end
        endcase
    end

    assign sel_n = mask8[NB-1:0] << off;
    assign dat_n = req_wdata << {off, 3'b000};
    assign adr_n = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign tmo   = (TIMEOUT != 0) && (cnt == TO_LAST);

    // Extract the addressed lane, then mask and extend to full width
    always_comb begin
        sh    = dat_i >> {off_r, 3'b000};
        lw    = 7'd8 << size_r;
        lmask = (DATA_W'(1) << lw) - DATA_W'(1);
        sbit  = 1'b0;
        unique case (size_r)
            2'b00:   sbit = sh[7];
            2'b01:   sbit = sh[15];
            2'b10:   sbit = sh[31];
            default: sbit = sh[DATA_W-1];
        endcase
        ld = (sh & lmask) | ((sgn_r && sbit) ? ~lmask : '0);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            adr_r   <= '0;
            dat_r   <= '0;
            sel_r   <= '0;
            off_r   <= '0;
            size_r  <= '0;
            sgn_r   <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        adr_r   <= adr_n;
                        dat_r   <= dat_n;
                        sel_r   <= sel_n;
                        off_r   <= off;
                        size_r  <= req_size;
                        sgn_r   <= req_signed;
                        we_r    <= req_we;
                        cnt     <= '0;
                        err_r   <= mis;
                        rdata_r <= '0;
                    end
                end
                BUS: begin
                    if (err_i) begin
                        err_r   <= 1'b1;
                        rdata_r <= '0;
                    end else if (ack_i) begin
                        err_r   <= 1'b0;
                        rdata_r <= we_r ? '0 : ld;
                    end else if (tmo) begin
                        err_r   <= 1'b1;
                        rdata_r <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req_valid) state_n = mis ? RESP : BUS;
            end
            BUS: begin
                if (err_i || ack_i || tmo) state_n = RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        cyc_o      = (state == BUS);
        stb_o      = (state == BUS);
        we_o       = (state == BUS) && we_r;
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_r;
        resp_rdata = (state == RESP) ? rdata_r : '0;
        adr_o      = adr_r;
        dat_o      = dat_r;
        sel_o      = sel_r;
    end

endmodule

// File: tb/tb_cpu_bus_lsu.sv
// Directed bench for cpu_bus_lsu: 32-bit instance with TIMEOUT=4,
// plus a 64-bit instance for wide lane steering.
module tb_cpu_bus_lsu;

    logic clk;
    logic rst_ni;

    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;
    logic        ack_i, err_i;

    logic        req_valid_b, req_ready_b, req_we_b, req_signed_b;
    logic [1:0]  req_size_b;
    logic [31:0] req_addr_b;
    logic [63:0] req_wdata_b;
    logic        resp_valid_b, resp_err_b;
    logic [63:0] resp_rdata_b;
    logic        cyc_b, stb_b, we_b;
    logic [31:0] adr_b;
    logic [63:0] dat_o_b, dat_i_b;
    logic [7:0]  sel_b;
    logic        ack_b, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_bus_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i)
    );

    cpu_bus_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) u64 (
        .clk(clk), .rst_ni(rst_ni),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_size(req_size_b), .req_signed(req_signed_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
        .resp_err(resp_err_b), .cyc_o(cyc_b), .stb_o(stb_b), .we_o(we_b),
        .adr_o(adr_b), .dat_o(dat_o_b), .sel_o(sel_b), .dat_i(dat_i_b),
        .ack_i(ack_b), .err_i(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // mode: 0 ack, 1 err, 2 ack+err, 3 never respond
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] din;
        int          delay;
        int          mode;
        int          nbus;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic        err;
    } vec_t;

    vec_t tv[14];

    task automatic run_vec(input int idx, input vec_t v);
        int  nbus;
        bit  seen;
        string tag;
        nbus = 0;
        seen = 1'b0;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            if (stb_o) begin
                if (nbus == 0) begin
                    chk({tag, " adr_o"}, 64'(adr_o), 64'(v.adr));
                    chk({tag, " sel_o"}, 64'(sel_o), 64'(v.sel));
                    chk({tag, " dat_o"}, 64'(dat_o), 64'(v.dat));
                    chk({tag, " we_o"}, 64'(we_o), 64'(v.we));
                    chk({tag, " cyc_o"}, 64'(cyc_o), 64'd1);
                end
                if (v.mode != 3 && nbus == v.delay) begin
                    ack_i = (v.mode != 1);
                    err_i = (v.mode != 0);
                    dat_i = v.din;
                end
                nbus++;
            end
            @(posedge clk);
            #1 ack_i = 1'b0; err_i = 1'b0; dat_i = 32'hDEAD_DEAD;
        end
        chk({tag, " resp_seen"}, 64'(seen), 64'd1);
        chk({tag, " bus_cycles"}, 64'(nbus), 64'(v.nbus));
        chk({tag, " resp_err"}, 64'(resp_err), 64'(v.err));
        chk({tag, " resp_rdata"}, 64'(resp_rdata), 64'(v.rdata));
        chk({tag, " cyc_in_resp"}, 64'(cyc_o), 64'd0);
        @(negedge clk);
        chk({tag, " resp_pulse"}, 64'(resp_valid), 64'd0);
        chk({tag, " ready_again"}, 64'(req_ready), 64'd1);
    endtask

    task automatic run64(input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] din,
                         input logic [7:0] esel, input logic [31:0] eadr,
                         input logic [63:0] erd);
        @(negedge clk);
        req_we_b = 1'b0; req_size_b = size; req_signed_b = sgn;
        req_addr_b = addr; req_wdata_b = '0; req_valid_b = 1'b1;
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        @(negedge clk);
        chk("w64 stb_o", 64'(stb_b), 64'd1);
        chk("w64 sel_o", 64'(sel_b), 64'(esel));
        chk("w64 adr_o", 64'(adr_b), 64'(eadr));
        ack_b = 1'b1; dat_i_b = din;
        @(posedge clk);
        #1 ack_b = 1'b0; dat_i_b = '0;
        @(negedge clk);
        chk("w64 resp_valid", 64'(resp_valid_b), 64'd1);
        chk("w64 resp_err", 64'(resp_err_b), 64'd0);
        chk("w64 resp_rdata", resp_rdata_b, erd);
    endtask

    initial begin
        tv[0]  = '{0, 2'b00, 1, 32'h103, 32'h0, 32'h80FFFF12, 0, 0, 1,
                   32'h100, 32'h0, 32'hFFFFFF80, 4'h8, 0};
        tv[1]  = '{1, 2'b01, 0, 32'h202, 32'hBEEF, 32'h12345678, 0, 0, 1,
                   32'h200, 32'hBEEF0000, 32'h0, 4'hC, 0};
        tv[2]  = '{0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 0, 0,
                   32'h0, 32'h0, 32'h0, 4'h0, 1};
        tv[3]  = '{0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0,
                   32'h0, 32'h0, 32'h0, 4'h0, 1};
        tv[4]  = '{0, 2'b01, 0, 32'h302, 32'h0, 32'hA5A51234, 2, 0, 3,
                   32'h300, 32'h0, 32'h0000A5A5, 4'hC, 0};
        tv[5]  = '{0, 2'b01, 1, 32'h300, 32'h0, 32'h12348001, 1, 0, 2,
                   32'h300, 32'h0, 32'hFFFF8001, 4'h3, 0};
        tv[6]  = '{0, 2'b00, 0, 32'h101, 32'h0, 32'h0000F700, 0, 0, 1,
                   32'h100, 32'h0, 32'h000000F7, 4'h2, 0};
        tv[7]  = '{1, 2'b00, 0, 32'h41, 32'hAB, 32'hFFFFFFFF, 0, 0, 1,
                   32'h40, 32'h0000AB00, 32'h0, 4'h2, 0};
        tv[8]  = '{1, 2'b10, 0, 32'h44, 32'hDEADBEEF, 32'h0, 1, 0, 2,
                   32'h44, 32'hDEADBEEF, 32'h0, 4'hF, 0};
        tv[9]  = '{0, 2'b10, 1, 32'h48, 32'h0, 32'h80000000, 0, 1, 1,
                   32'h48, 32'h0, 32'h0, 4'hF, 1};
        tv[10] = '{0, 2'b00, 1, 32'h4B, 32'h0, 32'hFF000000, 1, 2, 2,
                   32'h48, 32'h0, 32'h0, 4'h8, 1};
        tv[11] = '{0, 2'b10, 0, 32'h50, 32'h0, 32'h11111111, 0, 3, 4,
                   32'h50, 32'h0, 32'h0, 4'hF, 1};
        tv[12] = '{0, 2'b01, 0, 32'h203, 32'h0, 32'h0, 0, 0, 0,
                   32'h0, 32'h0, 32'h0, 4'h0, 1};
        tv[13] = '{0, 2'b10, 1, 32'h60, 32'h0, 32'h87654321, 0, 0, 1,
                   32'h60, 32'h0, 32'h87654321, 4'hF, 0};

        rst_ni = 1'b0;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; dat_i = 0; ack_i = 0; err_i = 0;
        req_valid_b = 0; req_we_b = 0; req_size_b = 0; req_signed_b = 0;
        req_addr_b = 0; req_wdata_b = 0; dat_i_b = 0; ack_b = 0; err_b = 0;

        #12;
        chk("rst cyc_o", 64'(cyc_o), 64'd0);
        chk("rst stb_o", 64'(stb_o), 64'd0);
        chk("rst we_o", 64'(we_o), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst resp_err", 64'(resp_err), 64'd0);
        chk("rst adr_o", 64'(adr_o), 64'd0);
        chk("rst dat_o", 64'(dat_o), 64'd0);
        chk("rst sel_o", 64'(sel_o), 64'd0);
        chk("rst resp_rdata", 64'(resp_rdata), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst req_ready", 64'(req_ready), 64'd1);

        // Bus strobes while idle must not produce a response
        ack_i = 1'b1; err_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack resp_valid", 64'(resp_valid), 64'd0);
            chk("idle_ack cyc_o", 64'(cyc_o), 64'd0);
        end
        ack_i = 1'b0; err_i = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, tv[i]);

        // Reset mid-BUS: strobe must fall before the next edge
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h80; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midrst stb_before", 64'(stb_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst cyc_o", 64'(cyc_o), 64'd0);
        chk("midrst stb_o", 64'(stb_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst no_resp", 64'(resp_valid), 64'd0);
            chk("midrst req_ready", 64'(req_ready), 64'd1);
        end

        run64(32'h1006, 2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0,
              8'hC0, 32'h1000, 64'h1234);
        run64(32'h1008, 2'b11, 1'b1, 64'h8000_0000_0000_0001,
              8'hFF, 32'h1008, 64'h8000_0000_0000_0001);
        run64(32'h1005, 2'b00, 1'b1, 64'h0000_9900_0000_0000,
              8'h20, 32'h1000, 64'hFFFF_FFFF_FFFF_FF99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
